// File: rtl/key_loader_pkg.sv
// key_loader_pkg: shared state encoding and sizing helpers for the key loader
package key_loader_pkg;
  localparam int KEY_W = 32;
  localparam int CHUNK_BITS = 8;
  localparam int TIMEOUT_DEF = 255;
  localparam int N_CHUNKS = KEY_W / CHUNK_BITS;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
  localparam int TO_W = cnt_w(TIMEOUT_DEF);
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, COMMIT, ERROR} state_t;
endpackage

// File: rtl/key_loader_if.sv
// key_loader_if: valid/ready key-chunk stream from the secure key store
interface key_loader_if import key_loader_pkg::*; #(parameter int CHUNK_W = CHUNK_BITS) ();
  logic s_valid;
  logic [CHUNK_W-1:0] s_data;
  logic s_ready;
  modport master (output s_valid, s_data, input s_ready);
  modport slave (input s_valid, s_data, output s_ready);
endinterface

// File: rtl/key_chk_accum.sv
// key_chk_accum: XOR checksum accumulator over key chunks with match against the received checksum
module key_chk_accum #(parameter int W = 8) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic [W-1:0] d,
  input  logic [W-1:0] chk,
  output logic match
);
  logic [W-1:0] acc_q;
  assign match = acc_q == chk;
  // running XOR of accepted key chunks, restarted at the beginning of each load
  always_ff @(posedge clk or posedge rst)
    if (rst) acc_q <= '0;
    else acc_q <= clr ? '0 : en ? acc_q ^ d : acc_q;
endmodule

// File: rtl/key_loader.sv
// key_loader: loads a chunked, checksummed unlock key and commits it to the locked core's key bus
module key_loader import key_loader_pkg::*; #(
  parameter int KEY_WIDTH = KEY_W,
  parameter int CHUNK_W = CHUNK_BITS,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF,
  parameter logic [KEY_WIDTH-1:0] DECOY_KEY = '0,
  parameter bit LOCK_ON_COMMIT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  key_loader_if.slave s,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic key_valid,
  output logic busy,
  output logic err_chk,
  output logic err_timeout,
  output logic lock
);
  localparam int N = KEY_WIDTH / CHUNK_W;
  localparam int BW = cnt_w(N);
  localparam int TW = cnt_w(TIMEOUT_CYC);
  localparam logic [BW-1:0] LAST = BW'(N);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  state_t state_q;
  logic [KEY_WIDTH-1:0] shadow_q, key_q;
  logic [BW-1:0] beat_q;
  logic [TW-1:0] to_q;
  logic [CHUNK_W-1:0] chk_q;
  logic ready_q, busy_q, valid_q, err_chk_q, err_to_q, lock_q;
  logic hs, go, match;
  assign hs = s.s_valid & ready_q;
  assign go = (state_q == IDLE) & start & ~lock_q;
  assign s.s_ready = ready_q;
  assign key_out = key_q;
  assign key_valid = valid_q;
  assign busy = busy_q;
  assign err_chk = err_chk_q;
  assign err_timeout = err_to_q;
  assign lock = lock_q;
  key_chk_accum #(.W(CHUNK_W)) u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (go),
    .en    (hs & (beat_q != LAST)),
    .d     (s.s_data),
    .chk   (chk_q),
    .match (match)
  );
  // load sequencer; every output is a register so the key bus never glitches
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      shadow_q <= '0;
      key_q <= DECOY_KEY;
      beat_q <= '0;
      to_q <= '0;
      chk_q <= '0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
      valid_q <= 1'b0;
      err_chk_q <= 1'b0;
      err_to_q <= 1'b0;
      lock_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (go) begin
          state_q <= LOAD;
          ready_q <= 1'b1;
          busy_q <= 1'b1;
          err_chk_q <= 1'b0;
          err_to_q <= 1'b0;
          beat_q <= '0;
          to_q <= '0;
        end
        LOAD: if (hs) begin
          to_q <= '0;
          if (beat_q == LAST) begin
            chk_q <= s.s_data;
            ready_q <= 1'b0;
            state_q <= CHECK;
          end else begin
            shadow_q[beat_q * CHUNK_W +: CHUNK_W] <= s.s_data;
            beat_q <= beat_q + 1'b1;
          end
        end else if (to_q == TO_LAST) begin
          ready_q <= 1'b0;
          err_to_q <= 1'b1;
          state_q <= ERROR;
        end else to_q <= to_q + 1'b1;
        CHECK: begin
          err_chk_q <= ~match;
          state_q <= match ? COMMIT : ERROR;
        end
        COMMIT: begin
          key_q <= shadow_q;
          valid_q <= 1'b1;
          lock_q <= LOCK_ON_COMMIT;
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
        ERROR: begin
          shadow_q <= '0;
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_key_loader.sv
// tb_key_loader: table-driven key load scenarios plus timeout and async-reset sequences
module tb_key_loader;
  import key_loader_pkg::*;
  localparam int TMO = (1 << TO_W) - 1;
  typedef struct {
    bit pre_rst;
    logic [31:0] key;
    logic [7:0] cs;
    bit spam;
    bit rnd;
    bit exp_started;
    logic [31:0] exp_key;
    bit exp_valid;
    bit exp_err;
    bit exp_lock;
  } vec_t;
  logic clk = 1'b0, rst, start;
  logic [31:0] key_out;
  logic key_valid, busy, err_chk, err_timeout, lock;
  int checks = 0, errors = 0;
  logic [31:0] cur_key;
  vec_t vec[6];
  bit st;
  key_loader_if #(.CHUNK_W(8)) ifc ();
  key_loader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .s           (ifc),
    .key_out     (key_out),
    .key_valid   (key_valid),
    .busy        (busy),
    .err_chk     (err_chk),
    .err_timeout (err_timeout),
    .lock        (lock)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cur_key = '0;
  endtask
  task automatic load(input logic [31:0] key, input logic [7:0] cs, input bit spam, input bit rnd,
                      input int gap_k, input int gap_len, input int nb, output bit started);
    logic [7:0] beat;
    int g, n;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = spam;
    started = busy;
    if (started)
      for (int k = 0; k < nb; k++) begin
        beat = (k == N_CHUNKS) ? cs : key[k*8 +: 8];
        g = rnd ? int'($urandom_range(0, 12)) : (k == gap_k ? gap_len : 0);
        if (g > 0) begin
          ifc.s_valid = 1'b0;
          repeat (g) @(negedge clk);
        end
        ifc.s_valid = 1'b1;
        ifc.s_data = beat;
        n = 0;
        while (!ifc.s_ready && n < 300) begin
          @(negedge clk);
          n++;
        end
        if (!ifc.s_ready) begin
          check("ready_wait", 32'(ifc.s_ready), 32'd1);
          break;
        end
        @(negedge clk);
      end
    start = 1'b0;
    ifc.s_valid = 1'b0;
  endtask
  task automatic post(input bit started, input bit exp_started, input logic [31:0] exp_key,
                      input bit exp_valid, input bit exp_err, input bit exp_lock, input string tag);
    check({tag, " started"}, 32'(started), 32'(exp_started));
    if (started) begin
      @(negedge clk);
      check({tag, " key_latency"}, key_out, cur_key);
      @(negedge clk);
    end else repeat (2) @(negedge clk);
    check({tag, " key_out"}, key_out, exp_key);
    check({tag, " key_valid"}, 32'(key_valid), 32'(exp_valid));
    check({tag, " err_chk"}, 32'(err_chk), 32'(exp_err));
    check({tag, " err_timeout"}, 32'(err_timeout), 32'd0);
    check({tag, " lock"}, 32'(lock), 32'(exp_lock));
    check({tag, " busy"}, 32'(busy), 32'd0);
    cur_key = exp_key;
  endtask
  initial begin
    vec[0] = '{1'b1, 32'hA5C31E7F, 8'h08, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0};
    vec[1] = '{1'b0, 32'hA5C31E7F, 8'h07, 1'b1, 1'b0, 1'b1, 32'hA5C31E7F, 1'b1, 1'b0, 1'b1};
    vec[2] = '{1'b0, 32'h12345678, 8'h08, 1'b0, 1'b0, 1'b0, 32'hA5C31E7F, 1'b1, 1'b0, 1'b1};
    vec[3] = '{1'b1, 32'h12345678, 8'h08, 1'b1, 1'b1, 1'b1, 32'h12345678, 1'b1, 1'b0, 1'b1};
    vec[4] = '{1'b1, 32'hDEADBEEF, 8'h23, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0};
    vec[5] = '{1'b0, 32'hDEADBEEF, 8'h22, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1};
    rst = 1'b1;
    start = 1'b0;
    ifc.s_valid = 1'b0;
    ifc.s_data = '0;
    cur_key = '0;
    repeat (2) @(negedge clk);
    check("rst key_out", key_out, 32'h0);
    check("rst key_valid", 32'(key_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst s_ready", 32'(ifc.s_ready), 32'd0);
    check("rst flags", {29'd0, err_chk, err_timeout, lock}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (vec[i].pre_rst) do_reset();
      load(vec[i].key, vec[i].cs, vec[i].spam, vec[i].rnd, -1, 0, N_CHUNKS + 1, st);
      post(st, vec[i].exp_started, vec[i].exp_key, vec[i].exp_valid, vec[i].exp_err,
           vec[i].exp_lock, $sformatf("vec%0d", i));
    end
    do_reset();
    load(32'hA5C31E7F, 8'h07, 1'b0, 1'b0, -1, 0, 2, st);
    check("tmo started", 32'(st), 32'd1);
    repeat (TMO - 1) @(negedge clk);
    check("tmo early busy", 32'(busy), 32'd1);
    check("tmo early flag", 32'(err_timeout), 32'd0);
    @(negedge clk);
    check("tmo flag", 32'(err_timeout), 32'd1);
    check("tmo s_ready", 32'(ifc.s_ready), 32'd0);
    @(negedge clk);
    check("tmo idle", 32'(busy), 32'd0);
    check("tmo key_out", key_out, 32'h0);
    check("tmo key_valid", 32'(key_valid), 32'd0);
    check("tmo err_chk", 32'(err_chk), 32'd0);
    do_reset();
    load(32'hA5C31E7F, 8'h07, 1'b0, 1'b0, 2, TMO - 1, N_CHUNKS + 1, st);
    post(st, 1'b1, 32'hA5C31E7F, 1'b1, 1'b0, 1'b1, "late_beat");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst key_out", key_out, 32'h0);
    check("arst key_valid", 32'(key_valid), 32'd0);
    check("arst lock", 32'(lock), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cur_key = '0;
    load(32'hA5C31E7F, 8'h07, 1'b0, 1'b0, -1, 0, 3, st);
    check("arst mid started", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst mid busy", 32'(busy), 32'd0);
    check("arst mid s_ready", 32'(ifc.s_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    load(32'hA5C31E7F, 8'h07, 1'b0, 1'b0, -1, 0, N_CHUNKS + 1, st);
    post(st, 1'b1, 32'hA5C31E7F, 1'b1, 1'b0, 1'b1, "after_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
